// File: rtl/line_mem_pkg.sv
// rtl/line_mem_pkg.sv - shared state encoding, width helper and parameter defaults for line_memory_arb
package line_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int DEF_LINE_W    = 256;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DEPTH     = 512;
    localparam int DEF_LATENCY   = 10;
    localparam int DEF_NUM_PORTS = 2;

    // Never returns zero so single-entry fields still get a legal vector.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_memory_arb_if.sv
// rtl/line_memory_arb_if.sv - multi-port request/ack bundle between requesters and line_memory_arb
interface line_memory_arb_if
    import line_mem_pkg::*;
#(
    parameter int LINE_W    = DEF_LINE_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_PORTS = DEF_NUM_PORTS
);
    logic [NUM_PORTS-1:0]        enable_i;
    logic [NUM_PORTS-1:0]        write_i;
    logic [NUM_PORTS*ADDR_W-1:0] addr_i;
    logic [NUM_PORTS*LINE_W-1:0] data_i;
    logic [NUM_PORTS-1:0]        ack_o;
    logic [LINE_W-1:0]           data_o;
    logic                        busy_o;

    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  ack_o, data_o, busy_o
    );

    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output ack_o, data_o, busy_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr_i
module rr_arbiter
    import line_mem_pkg::*;
#(
    parameter  int NUM_PORTS = DEF_NUM_PORTS,
    localparam int PW        = width_of(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PW-1:0]        ptr_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PW-1:0]        grant_idx_o,
    output logic                 any_o
);

    int p;

    // Scan from the farthest offset back to the pointer so the nearest requester wins last.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = |req_i;
        p           = 0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            p = (int'(ptr_i) + i) % NUM_PORTS;
            if (req_i[p]) begin
                grant_o     = NUM_PORTS'(1) << p;
                grant_idx_o = PW'(p);
            end
        end
    end

endmodule

// File: rtl/line_memory_arb.sv
// rtl/line_memory_arb.sv - line-granular backing memory with round-robin ports and fixed access latency
module line_memory_arb
    import line_mem_pkg::*;
#(
    parameter int LINE_W    = DEF_LINE_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic               clk_i,
    input  logic               rst_i,
    line_memory_arb_if.slave   bus
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = width_of(DEPTH);
    localparam int PW    = width_of(NUM_PORTS);
    localparam int CNT_W = width_of(LATENCY);

    // Offset bits drop out, upper bits wrap silently.
    function automatic logic [IDX_W-1:0] line_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] s;
        s = a >> OFF_W;
        return s[IDX_W-1:0];
    endfunction

    logic [LINE_W-1:0] mem [DEPTH];

    state_e               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        g_q,      g_d;
    logic [NUM_PORTS-1:0] g_oh_q,   g_oh_d;
    logic                 wr_q,     wr_d;
    logic [IDX_W-1:0]     idx_q,    idx_d;
    logic [LINE_W-1:0]    wdata_q,  wdata_d;
    logic [LINE_W-1:0]    data_q,   data_d;

    logic [NUM_PORTS-1:0] arb_grant;
    logic [PW-1:0]        arb_idx;
    logic                 arb_any;
    logic [ADDR_W-1:0]    sel_addr;
    logic [LINE_W-1:0]    sel_data;
    logic                 sel_write;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .req_i       (bus.enable_i),
        .ptr_i       (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    assign sel_addr  = bus.addr_i[int'(arb_idx) * ADDR_W +: ADDR_W];
    assign sel_data  = bus.data_i[int'(arb_idx) * LINE_W +: LINE_W];
    assign sel_write = bus.write_i[arb_idx];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        g_d      = g_q;
        g_oh_d   = g_oh_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        data_d   = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    g_d     = arb_idx;
                    g_oh_d  = arb_grant;
                    wr_d    = sel_write;
                    idx_d   = line_idx(sel_addr);
                    wdata_d = sel_data;
                    if (LATENCY == 1) begin
                        state_d = ST_ACK;
                        if (!sel_write) begin
                            data_d = mem[idx_d];
                        end
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    if (!wr_q) begin
                        data_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                state_d  = ST_IDLE;
                rr_ptr_d = (int'(g_q) == NUM_PORTS - 1) ? '0 : g_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            g_q      <= '0;
            g_oh_q   <= '0;
            wr_q     <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            g_q      <= g_d;
            g_oh_q   <= g_oh_d;
            wr_q     <= wr_d;
            idx_q    <= idx_d;
            wdata_q  <= wdata_d;
            data_q   <= data_d;
        end
    end

    // Contents survive reset; an aborted write never reaches ACK so it never lands.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_ACK && wr_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.ack_o  = (state_q == ST_ACK) ? g_oh_q : '0;
    assign bus.busy_o = (state_q != ST_IDLE);
    assign bus.data_o = data_q;

endmodule

// File: tb/tb_line_memory_arb.sv
// tb/tb_line_memory_arb.sv - scoreboard bench for line_memory_arb against a queue-based reference model
module tb_line_memory_arb;

    localparam int LW  = 256;
    localparam int AW  = 32;
    localparam int DP  = 512;
    localparam int LAT = 10;
    localparam int NP  = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_memory_arb_if #(.LINE_W(LW), .ADDR_W(AW), .NUM_PORTS(NP)) bus ();
    line_memory_arb #(
        .LINE_W(LW), .ADDR_W(AW), .DEPTH(DP), .LATENCY(LAT), .NUM_PORTS(NP)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    line_memory_arb_if #(.LINE_W(32), .ADDR_W(16), .NUM_PORTS(1)) bus2 ();
    line_memory_arb #(
        .LINE_W(32), .ADDR_W(16), .DEPTH(16), .LATENCY(1), .NUM_PORTS(1)
    ) dut2 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        int unsigned   cyc;
        bit            chk;
        logic [LW-1:0] data;
    } exp_t;

    exp_t          expq [NP][$];
    exp_t          mon_e;
    logic [LW-1:0] mdl [int];
    int            mptr = 0;

    function automatic void check(input bit ok, input string name,
                                  input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'((a >> 5) % 32'(DP));
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Served order follows the round-robin pointer; each later grant costs LAT+1 cycles.
    task automatic issue_round(input bit [1:0] en, input bit [1:0] wr,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [LW-1:0] d0, input logic [LW-1:0] d1);
        logic [AW-1:0] a [NP];
        logic [LW-1:0] d [NP];
        int            order [$];
        int unsigned   t;
        exp_t          e;
        int            p;
        int            ix;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        @(negedge clk);
        t = cyc;
        for (int q = 0; q < NP; q++) begin
            bus.enable_i[q]        = en[q];
            bus.write_i[q]         = wr[q];
            bus.addr_i[q*AW +: AW] = a[q];
            bus.data_i[q*LW +: LW] = d[q];
        end
        for (int k = 0; k < NP; k++) begin
            p = (mptr + k) % NP;
            if (en[p]) order.push_back(p);
        end
        for (int j = 0; j < order.size(); j++) begin
            p     = order[j];
            ix    = idx_of(a[p]);
            e.cyc = t + LAT + j * (LAT + 1);
            if (wr[p]) begin
                mdl[ix] = d[p];
                e.chk   = 1'b0;
                e.data  = '0;
            end else begin
                e.chk  = mdl.exists(ix);
                e.data = e.chk ? mdl[ix] : '0;
            end
            expq[p].push_back(e);
            mptr = (p + 1) % NP;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            for (int q = 0; q < NP; q++) if (bus.ack_o[q]) bus.enable_i[q] = 1'b0;
            n++;
        end while ((expq[0].size() != 0 || expq[1].size() != 0) && n < NP * (LAT + 1) + LAT + 10);
        check(expq[0].size() == 0 && expq[1].size() == 0, "ack_timeout",
              expq[0].size() + expq[1].size(), 0);
        if (expq[0].size() != 0 || expq[1].size() != 0) begin
            expq[0].delete();
            expq[1].delete();
            bus.enable_i = '0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.ack_o != '0) begin
            check($countones(bus.ack_o) == 1, "ack_onehot", bus.ack_o, 1);
            for (int p = 0; p < NP; p++) begin
                if (bus.ack_o[p]) begin
                    if (expq[p].size() == 0) begin
                        check(1'b0, "unexpected_ack", p, 0);
                    end else begin
                        mon_e = expq[p].pop_front();
                        check(cyc == mon_e.cyc, "ack_cycle", cyc, mon_e.cyc);
                        if (mon_e.chk) check(bus.data_o == mon_e.data, "read_data", bus.data_o, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        logic [AW-1:0] ra0, ra1;
        int unsigned   t;
        bit            ex;
        bus.enable_i  = '0; bus.write_i  = '0; bus.addr_i  = '0; bus.data_i  = '0;
        bus2.enable_i = '0; bus2.write_i = '0; bus2.addr_i = '0; bus2.data_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check(bus.ack_o == '0, "reset_ack", bus.ack_o, 0);
        check(bus.busy_o == 1'b0, "reset_busy", bus.busy_o, 0);
        check(bus.data_o == '0, "reset_data", bus.data_o, 0);
        rst_n = 1'b1;

        issue_round(2'b11, 2'b11, 32'h0000, 32'h0020, rnd_line(), rnd_line()); wait_done();
        issue_round(2'b01, 2'b01, 32'h0040, 32'h0000, rnd_line(), '0);         wait_done();
        issue_round(2'b11, 2'b11, 32'h0060, 32'h0080, rnd_line(), rnd_line()); wait_done();
        for (int i = 5; i < 16; i += 2) begin
            issue_round(2'b11, 2'b11, 32'(i) << 5, 32'(i + 1) << 5, rnd_line(), rnd_line());
            wait_done();
        end

        issue_round(2'b01, 2'b01, 32'h40, 32'h0, {32{8'hA5}}, '0); wait_done();
        issue_round(2'b01, 2'b00, 32'h40, 32'h0, '0, '0);
        repeat (2) @(negedge clk);
        check(bus.busy_o == 1'b1, "busy_in_wait", bus.busy_o, 1);
        wait_done();
        check(mdl[2] == {32{8'hA5}}, "a5_model_line", mdl[2], {32{8'hA5}});

        issue_round(2'b01, 2'b01, 32'h4000, 32'h0, rnd_line(), '0); wait_done();
        issue_round(2'b10, 2'b00, 32'h0, 32'h0000, '0, '0);         wait_done();
        issue_round(2'b01, 2'b00, 32'h0005, 32'h0, '0, '0);         wait_done();

        issue_round(2'b10, 2'b10, 32'h0, 32'h100, '0, rnd_line());
        repeat (3) @(negedge clk);
        bus.addr_i[AW +: AW] = 32'h120;
        bus.data_i[LW +: LW] = rnd_line();
        wait_done();
        issue_round(2'b11, 2'b00, 32'h100, 32'h120, '0, '0); wait_done();

        @(negedge clk);
        bus.enable_i[0]  = 1'b1;
        bus.write_i[0]   = 1'b1;
        bus.addr_i[0 +: AW] = 32'h20;
        bus.data_i[0 +: LW] = rnd_line();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check(bus.busy_o == 1'b0, "abort_busy", bus.busy_o, 0);
        check(bus.ack_o == '0, "abort_ack", bus.ack_o, 0);
        bus.enable_i = '0;
        repeat (2) @(negedge clk);
        check(bus.data_o == '0, "abort_data", bus.data_o, 0);
        rst_n = 1'b1;
        mptr  = 0;
        issue_round(2'b01, 2'b00, 32'h20, 32'h0, '0, '0); wait_done();

        for (int r = 0; r < 40; r++) begin
            ra0 = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 5) | ($urandom & 32'h1F);
            ra1 = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 5) | ($urandom & 32'h1F);
            issue_round(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), ra0, ra1, rnd_line(), rnd_line());
            wait_done();
        end

        @(negedge clk);
        bus2.enable_i = 1'b1;
        bus2.write_i  = 1'b1;
        bus2.addr_i   = 16'h0008;
        bus2.data_i   = 32'hDEADBEEF;
        t = cyc;
        @(negedge clk);
        check(bus2.ack_o == 1'b1 && cyc == t + 1, "l1_write_ack", {bus2.ack_o, cyc}, {1'b1, t + 1});
        bus2.enable_i = 1'b0;
        @(negedge clk);
        bus2.write_i  = 1'b0;
        bus2.enable_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            ex = (k % 2) == 1;
            check(bus2.ack_o == ex, "l1_ack_pattern", bus2.ack_o, ex);
            check(bus2.busy_o == ex, "l1_busy_pattern", bus2.busy_o, ex);
            if (ex) check(bus2.data_o == 32'hDEADBEEF, "l1_read_data", bus2.data_o, 32'hDEADBEEF);
        end
        bus2.enable_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
